// File: rtl/typing_ctrl.sv
// typing_ctrl: typing-race sequencer tracking cursor, correctness mask, errors and seconds.
// Define TYPING_STRICT_EN so a wrong letter only counts an error and never advances.
module typing_ctrl #(
    parameter int NCHAR  = 25,
    parameter int CLK_HZ = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [5*NCHAR-1:0] text_in,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    input  logic               key_bksp,
    output logic [5*NCHAR-1:0] text,
    output logic [4:0]         cursor,
    output logic [NCHAR-1:0]   ok_mask,
    output logic [7:0]         err_count,
    output logic [7:0]         elapsed_s,
    output logic [1:0]         state,
    output logic               done
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [4:0] LAST = 5'(NCHAR);
    localparam logic [PW-1:0] WRAP = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    state_t             r_state, w_state_nxt;
    logic [5*NCHAR-1:0] r_text;
    logic [4:0]         r_cursor, w_cursor_nxt;
    logic [NCHAR-1:0]   r_mask, w_mask_nxt;
    logic [7:0]         r_err, w_err_nxt, r_sec;
    logic [PW-1:0]      r_presc;
    logic               r_done;
    logic [4:0]         w_char;
    logic               w_bksp, w_type, w_match;

    always_comb begin
        w_char = '0;
        for (int i = 0; i < NCHAR; i++)
            if (int'(r_cursor) == i) w_char = r_text[5*i +: 5];
        w_match = key_code == w_char;
        w_bksp = key_bksp && r_state == RUN && r_cursor != 5'd0;
        w_type = !key_bksp && key_valid && key_code <= 5'd25 &&
                 (r_state == ARMED || r_state == RUN) && r_cursor < LAST;
        w_cursor_nxt = r_cursor;
        w_mask_nxt = r_mask;
        w_err_nxt = r_err;
        w_state_nxt = r_state;
        if (w_bksp) begin
            w_cursor_nxt = r_cursor - 5'd1;
            w_mask_nxt[r_cursor - 5'd1] = 1'b0;
        end else if (w_type) begin
`ifdef TYPING_STRICT_EN
            w_cursor_nxt = w_match ? r_cursor + 5'd1 : r_cursor;
            if (w_match) w_mask_nxt[r_cursor] = 1'b1;
`else
            w_cursor_nxt = r_cursor + 5'd1;
            w_mask_nxt[r_cursor] = w_match;
`endif
            if (!w_match) w_err_nxt = r_err + {7'd0, r_err != 8'hFF};
            // Completion is decided on the post-key values so DONE lands with the last key.
            w_state_nxt = (w_cursor_nxt == LAST && &w_mask_nxt) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_text <= '0;
            r_cursor <= '0;
            r_mask <= '0;
            r_err <= '0;
            r_sec <= '0;
            r_presc <= '0;
            r_state <= IDLE;
            r_done <= 1'b0;
        end else if (load) begin
            r_text <= text_in;
            r_cursor <= '0;
            r_mask <= '0;
            r_err <= '0;
            r_sec <= '0;
            r_presc <= '0;
            r_state <= ARMED;
            r_done <= 1'b0;
        end else begin
            r_cursor <= w_cursor_nxt;
            r_mask <= w_mask_nxt;
            r_err <= w_err_nxt;
            r_state <= w_state_nxt;
            r_done <= w_state_nxt == DONE;
            if (r_state == RUN) begin
                r_presc <= (r_presc == WRAP) ? '0 : r_presc + PW'(1);
                if (r_presc == WRAP) r_sec <= r_sec + {7'd0, r_sec != 8'hFF};
            end
        end
    end

    assign text = r_text;
    assign cursor = r_cursor;
    assign ok_mask = r_mask;
    assign err_count = r_err;
    assign elapsed_s = r_sec;
    assign state = r_state;
    assign done = r_done;
endmodule
